// File: rtl/fetch_unit_pkg.sv
// Shared types, widths and encodings for the instruction-fetch stage.
// Optional build macro: FETCH_PERF_CNT_EN (fetch/drop performance counters).
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef INSTR_BYTES
`define INSTR_BYTES 4
`endif
`ifndef FETCH_S_REQ
`define FETCH_S_REQ 1'b0
`endif
`ifndef FETCH_S_WAIT
`define FETCH_S_WAIT 1'b1
`endif

package fetch_unit_pkg;
  localparam int unsigned ADDR_W      = `ADDR_SIZE;
  localparam int unsigned WORD_W      = `WORD_LEN;
  localparam int unsigned INSTR_BYTES = `INSTR_BYTES;

  typedef enum logic {
    S_REQ  = `FETCH_S_REQ,
    S_WAIT = `FETCH_S_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push is accepted when full only alongside a pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding imem request, {pc, instr} buffer to decode.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [WORD_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] perf_fetched,
  output logic [WORD_W-1:0] perf_dropped
`endif
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state;
  fetch_state_t      state_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              drop;
  logic              hs;
  logic              resp;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_n;
  fetch_entry_t      din;
  fetch_entry_t      head;
  logic              unused_sigs;

  assign unused_sigs = ^{redirect_addr[0], fifo_full};

  // Redirect discards any same-cycle push/pop; the FIFO flush does the rest.
  assign hs      = imem_req_valid & imem_req_ready;
  assign resp    = (state == S_WAIT) & imem_resp_valid;
  assign push    = resp & ~drop & ~redirect_valid;
  assign pop     = if_valid & if_ready & ~redirect_valid;
  assign count_n = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign state_n = (state == S_REQ) ? (hs ? S_WAIT : S_REQ)
                                    : (imem_resp_valid ? S_REQ : S_WAIT);

  assign imem_req_addr = fetch_pc;
  assign if_valid      = ~fifo_empty;
  assign if_pc         = head.pc;
  assign if_instr      = head.instr;
  assign din           = '{pc: req_pc, instr: imem_resp_data};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .din   (din),
    .dout  (head)
  );

  // Request FSM; request valid is registered from next state and next occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_REQ;
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
    end else begin
      state          <= state_n;
      imem_req_valid <= (state_n == S_REQ) && (count_n < CNT_W'(FIFO_DEPTH));
      if (hs) req_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_addr[ADDR_W-1:1], 1'b0};
      else if (hs)
        fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
      // An in-flight request at redirect time must have its response killed.
      if (redirect_valid)
        drop <= ((state == S_WAIT) && !imem_resp_valid) || hs;
      else if (resp)
        drop <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + WORD_W'(1);
      if (resp && (drop || redirect_valid)) perf_dropped <= perf_dropped + WORD_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple memory responder and decode-side pop log.
module tb_fetch_unit;
  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int resp_lat = 1;
  int pend_cnt = -1;
  logic [31:0] pend_addr;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: response pulse resp_lat cycles after the accept cycle.
  always @(negedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (reset) begin
      pend_cnt = -1;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = pend_addr ^ KEY;
          pend_cnt        = -1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        req_log.push_back(imem_req_addr);
        pend_addr = imem_req_addr;
        pend_cnt  = resp_lat;
      end
    end
  end

  // Decode side: record every pop that survives (a redirect discards it).
  always @(negedge clk) begin
    #1;
    if (!reset && if_valid && if_ready && !redirect_valid) begin
      pop_pc.push_back(if_pc);
      pop_instr.push_back(if_instr);
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    resp_lat = 1;
    repeat (2) @(negedge clk);
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    reset = 1'b0;
  endtask

  task automatic wait_hs(input logic [31:0] addr, input string tag);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && imem_req_addr == addr) ok = 1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: no request at 0x%08h within 60 cycles", tag, addr);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
  endtask

  task automatic test_stream();
    reset_dut();
    if_ready = 1'b1;
    wait_hs(32'h0, "stream_first_req");
    @(negedge clk);
    chk("stream_valid_t1", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("stream_valid_t2", 32'(if_valid), 32'd1);
    chk("stream_head_pc", if_pc, 32'h0);
    chk("stream_head_instr", if_instr, 32'h0 ^ KEY);
    repeat (16) @(negedge clk);
    chk("stream_pop_cnt_ge4", 32'(pop_pc.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
      chk("stream_req", req_log[i], 32'(4 * i));
      chk("stream_pop_pc", pop_pc[i], 32'(4 * i));
      chk("stream_pop_instr", pop_instr[i], 32'(4 * i) ^ KEY);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    repeat (10) @(negedge clk);
    chk("bp_req_count", 32'(req_log.size()), 32'd2);
    chk("bp_req_valid_full", 32'(imem_req_valid), 32'd0);
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    chk("bp_head_pc", if_pc, 32'h0);
    chk("bp_no_pops", 32'(pop_pc.size()), 32'd0);
    if_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_pops_ge2", 32'(pop_pc.size() >= 2 && req_log.size() >= 3), 32'd1);
    if (pop_pc.size() >= 2 && req_log.size() >= 3) begin
      chk("bp_pop0", pop_pc[0], 32'h0);
      chk("bp_pop1", pop_pc[1], 32'h4);
      chk("bp_resume_req", req_log[2], 32'h8);
    end
  endtask

  task automatic test_redirect_wait();
    reset_dut();
    resp_lat = 3;
    if_ready = 1'b1;
    wait_hs(32'h8, "rw_req8");
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rw_fetch_addr", imem_req_addr, 32'h100);
    chk("rw_req_valid_wait", 32'(imem_req_valid), 32'd0);
    repeat (20) @(negedge clk);
    chk("rw_sizes", 32'(req_log.size() >= 4 && pop_pc.size() >= 3), 32'd1);
    if (req_log.size() >= 4 && pop_pc.size() >= 3) begin
      chk("rw_next_req", req_log[3], 32'h100);
      chk("rw_pop1", pop_pc[1], 32'h4);
      chk("rw_pop2_pc", pop_pc[2], 32'h100);
      chk("rw_pop2_instr", pop_instr[2], 32'h100 ^ KEY);
    end
  endtask

  task automatic test_redirect_hs();
    reset_dut();
    if_ready = 1'b1;
    wait_hs(32'hC, "rh_reqC");
    redirect_valid = 1'b1;
    redirect_addr  = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rh_if_valid", 32'(if_valid), 32'd0);
    chk("rh_fetch_addr", imem_req_addr, 32'h202);
    chk("rh_req_valid_wait", 32'(imem_req_valid), 32'd0);
    repeat (12) @(negedge clk);
    chk("rh_sizes", 32'(req_log.size() >= 5 && pop_pc.size() >= 4), 32'd1);
    if (req_log.size() >= 5 && pop_pc.size() >= 4) begin
      chk("rh_req4", req_log[4], 32'h202);
      chk("rh_pop1", pop_pc[1], 32'h4);
      chk("rh_pop2", pop_pc[2], 32'h202);
      chk("rh_pop3", pop_pc[3], 32'h206);
    end
  endtask

  task automatic test_redirect_resp();
    reset_dut();
    wait_hs(32'h4, "rr_req4");
    @(negedge clk);
    chk("rr_held_valid", 32'(if_valid), 32'd1);
    chk("rr_held_pc", if_pc, 32'h0);
    chk("rr_held_instr", if_instr, KEY);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rr_if_valid", 32'(if_valid), 32'd0);
    chk("rr_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rr_req_addr", imem_req_addr, 32'h40);
    if_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("rr_pops", 32'(pop_pc.size() >= 1), 32'd1);
    if (pop_pc.size() >= 1) chk("rr_pop0", pop_pc[0], 32'h40);
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    resp_lat = 3;
    if_ready = 1'b1;
    wait_hs(32'h4, "rm_req4");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rm_if_valid", 32'(if_valid), 32'd0);
    chk("rm_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    resp_lat = 1;
    reset = 1'b0;
    @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    chk("rm_perf_fetched", perf_fetched, 32'd0);
    chk("rm_perf_dropped", perf_dropped, 32'd0);
`endif
    repeat (12) @(negedge clk);
    chk("rm_sizes", 32'(req_log.size() >= 1 && pop_pc.size() >= 1), 32'd1);
    if (req_log.size() >= 1 && pop_pc.size() >= 1) begin
      chk("rm_req0", req_log[0], 32'h0);
      chk("rm_pop0_pc", pop_pc[0], 32'h0);
      chk("rm_pop0_instr", pop_instr[0], KEY);
    end
  endtask

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_addr   = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hs();
    test_redirect_resp();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register and address adder.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake, with at most one request outstanding.
- Buffers returned {pc, instr} pairs in a small FIFO that feeds decode.
- Accepts redirects from the branch controller; on a redirect it flushes the buffer and kills any in-flight response.

Parameters:
- RESET_PC, `ADDR_SIZE'h00000000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, number of {pc, instr} entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; load new fetch PC.
- redirect_addr  in  `ADDR_SIZE  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  `ADDR_SIZE  word address requested.
- imem_resp_valid  in  1  one-cycle pulse carrying read data; never precedes its accept cycle.
- imem_resp_data  in  `WORD_LEN  instruction word.
- if_valid  out  1  FIFO head valid toward decode.
- if_ready  in  1  decode consumes the head.
- if_pc  out  `ADDR_SIZE  PC of the head entry.
- if_instr  out  `WORD_LEN  instruction of the head entry.

Behaviour:
- Reset (async, active-high):
  - fetch_pc = RESET_PC; state = S_REQ; FIFO empty; drop flag = 0.
  - All outputs are 0 while reset is asserted, including imem_req_valid.
  - Reset mid-transaction abandons the outstanding request. Memory must also be reset; no response is expected afterwards.
- FSM states: S_REQ, S_WAIT.
- S_REQ:
  - imem_req_valid = 1 iff FIFO count < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On valid & ready: latch req_pc = fetch_pc; fetch_pc += 4 (wraps modulo 2^`ADDR_SIZE); go to S_WAIT.
- S_WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid: if drop = 0, push {req_pc, imem_resp_data}. Clear drop; go to S_REQ.
  - Earliest resp is the cycle after accept, so latency is ≥2 cycles from request to if_valid.
- Push happens only when a slot was reserved at request time, so the FIFO never overflows.
- Push and pop in the same cycle are legal at any count.
- Pop (if_valid & if_ready):
  - Head advances on the next edge.
  - if_pc and if_instr are valid only while if_valid = 1 and stay stable until popped.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Redirect (highest priority, synchronous):
  - fetch_pc <= {redirect_addr[`ADDR_SIZE-1:1], 1'b0}.
  - FIFO flushed (count = 0); any same-cycle pop or push is discarded; if_valid = 0 the next cycle.
  - If state is S_WAIT and no resp arrives that cycle: drop <= 1.
  - If a resp arrives in the redirect cycle, that response is discarded and state goes to S_REQ.
  - If a request handshake occurs in the redirect cycle: the request is outstanding; state becomes S_WAIT with drop = 1; fetch_pc = redirect target, with no +4.
  - In S_REQ with no handshake: the next request uses the target.
- Back-to-back redirects: the last one wins; the drop flag stays set until one response is absorbed.
- No combinational path from redirect_valid to imem_req_addr. The new address appears the cycle after the redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched and perf_dropped, both `WORD_LEN.
  - perf_fetched increments on each FIFO push.
  - perf_dropped increments on each discarded response.
  - Both reset to 0 and wrap.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- defines.v:
  - uses `ADDR_SIZE and `WORD_LEN.
  - add `INSTR_BYTES (4) for the PC increment.
  - add `FETCH_S_REQ and `FETCH_S_WAIT (1-bit encodings).
- Sub-module fetch_fifo:
  - parameterised by width and depth.
  - ports: push, pop, flush, full, empty, count, din, dout.
  - async reset, same clk/reset names.

Test Plan:
- Reset release, imem ready always, resp 1 cycle after accept, data = addr^32'hA5A5A5A5, if_ready = 1 → requests at 0, 4, 8, …; if_pc/if_instr pairs match in order; first if_valid 2 cycles after the first accept.
- if_ready = 0 for 10 cycles → exactly 2 entries buffered; imem_req_valid = 0 while full. Release if_ready → pops 0, 4, then fetch resumes at 8.
- Redirect to 0x100 while in S_WAIT for 0x8; resp arrives 3 cycles later → response dropped, never visible; next request addr = 0x100.
- Redirect to 0x203 coincident with a req handshake at 0xC → FIFO flushed; the 0xC response is dropped; next request addr = 0x202.
- Redirect coincident with imem_resp_valid, FIFO holding 1 entry → if_valid = 0 the next cycle; that response is discarded.
- Reset asserted mid-S_WAIT, then released → fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, both counters read 0.
